// File: rtl/branch_pkg.sv
// Shared branch op codes, BHT reset value and branch-code decode.
// Imported by the branch resolve unit and its history table.
package branch_pkg;

  localparam logic [6:0] ALU_BEQ  = 7'b0001010;
  localparam logic [6:0] ALU_BNE  = 7'b0001100;
  localparam logic [6:0] ALU_BLT  = 7'b0001110;
  localparam logic [6:0] ALU_BGE  = 7'b0010000;
  localparam logic [6:0] ALU_BLTU = 7'b0010010;
  localparam logic [6:0] ALU_BGEU = 7'b0010100;

  // Weakly not-taken
  localparam logic [1:0] BHT_RESET = 2'b01;

  function automatic logic is_branch_code(input logic [6:0] alu_sel);
    case (alu_sel)
      ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/branch_history_table.sv
// 2-bit saturating branch history table: combinational read, one update per cycle.
// Update takes effect after the clock edge; a same-index read in that cycle sees the old value.
module branch_history_table
  import branch_pkg::*;
#(
  parameter int BHT_DEPTH = 16,
  parameter int IDXW      = $clog2(BHT_DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IDXW-1:0] rd_idx,
  output logic [1:0]      rd_cnt,
  input  logic            upd_en,
  input  logic [IDXW-1:0] upd_idx,
  input  logic            upd_taken
);

  logic [1:0] cnt_q [BHT_DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) cnt_q[i] <= BHT_RESET;
    end else if (upd_en) begin
      if (upd_taken && cnt_q[upd_idx] != 2'b11)
        cnt_q[upd_idx] <= cnt_q[upd_idx] + 2'd1;
      else if (!upd_taken && cnt_q[upd_idx] != 2'b00)
        cnt_q[upd_idx] <= cnt_q[upd_idx] - 2'd1;
    end
  end

  assign rd_cnt = cnt_q[rd_idx];

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves RV32 branch conditions and next PC, flags mispredicts, trains the BHT.
// Latency 1 cycle; one-entry output register, in_ready drops while a result is stalled.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_taken,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      aluSelect,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            in_pred_taken,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            is_branch,
  output logic            branch_taken,
  output logic [XLEN-1:0] target,
  output logic            mispredict,
  output logic [31:0]     mispredict_count
);

  localparam int IDXW = $clog2(BHT_DEPTH);

  logic            accept;
  logic            fire;
  logic            c_is_branch;
  logic            c_taken;
  logic            c_mispredict;
  logic [XLEN-1:0] c_target;
  logic [IDXW-1:0] idx_q;
  logic [1:0]      pred_cnt;
  logic            unused_bits;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign fire     = out_valid && out_ready;

  always_comb begin
    c_is_branch = is_branch_code(aluSelect);
    case (aluSelect)
      ALU_BEQ:  c_taken = (rs1 == rs2);
      ALU_BNE:  c_taken = (rs1 != rs2);
      ALU_BLT:  c_taken = ($signed(rs1) <  $signed(rs2));
      ALU_BGE:  c_taken = ($signed(rs1) >= $signed(rs2));
      ALU_BLTU: c_taken = (rs1 <  rs2);
      ALU_BGEU: c_taken = (rs1 >= rs2);
      default:  c_taken = 1'b0;
    endcase
    c_target     = c_taken ? (pc + imm) : (pc + XLEN'(4));
    c_mispredict = (c_taken != in_pred_taken);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid    <= 1'b0;
      is_branch    <= 1'b0;
      branch_taken <= 1'b0;
      target       <= '0;
      mispredict   <= 1'b0;
      idx_q        <= '0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      is_branch    <= c_is_branch;
      branch_taken <= c_taken;
      target       <= c_target;
      mispredict   <= c_mispredict;
      idx_q        <= pc[IDXW+1:2];
    end else if (fire) begin
      out_valid <= 1'b0;
    end
  end

  // Counter sticks at all-ones rather than wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      mispredict_count <= '0;
    else if (fire && mispredict && mispredict_count != 32'hFFFF_FFFF)
      mispredict_count <= mispredict_count + 32'd1;
  end

  branch_history_table #(
    .BHT_DEPTH (BHT_DEPTH)
  ) u_bht (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (pred_pc[IDXW+1:2]),
    .rd_cnt    (pred_cnt),
    .upd_en    (fire && is_branch),
    .upd_idx   (idx_q),
    .upd_taken (branch_taken)
  );

  assign pred_taken  = pred_cnt[1];
  assign unused_bits = ^{pred_pc[XLEN-1:IDXW+2], pred_pc[1:0], pred_cnt[0]};

endmodule
